// File: rtl/mc_dcb.sv
// Multi-channel DC-block filter: one shared datapath serves NCH channels.
// Each channel keeps its own acc/y state, and a two-stage pipeline drives the output.
module mc_dcb #(
  parameter int DSZ  = 16,
  parameter int NCH  = 4,
  parameter int SMAX = 15,
  parameter int CHW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [DSZ-1:0] in,
  input  logic [CHW-1:0]        in_ch,
  input  logic                  ena,
  input  logic [3:0]            shift,
  input  logic                  freeze,
  input  logic                  bypass,
  input  logic                  clr,
  output logic signed [DSZ-1:0] out,
  output logic [CHW-1:0]        out_ch,
  output logic                  valid,
  output logic                  sat
);

  localparam int AW = DSZ + SMAX + 1;
  localparam int DW = DSZ + 1;
  localparam logic [CHW:0] NCH_W  = (CHW+1)'(NCH);
  localparam logic [3:0]   SMAX_W = 4'(SMAX);

  logic signed [AW-1:0] acc [NCH];
  logic signed [DW-1:0] y   [NCH];

  logic                 ch_ok;
  logic                 take;
  logic [3:0]           k;
  logic signed [AW-1:0] acc_sel;
  logic signed [AW-1:0] acc_shr;
  logic signed [DW-1:0] in_ext;
  logic signed [DW-1:0] d;

  // A clear in the ena cycle makes the sample see zeroed state, so d = in.
  always_comb begin
    ch_ok   = ({1'b0, in_ch} < NCH_W);
    take    = ena && ch_ok;
    k       = (shift > SMAX_W) ? SMAX_W : shift;
    acc_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!clr && (in_ch == CHW'(i))) acc_sel = acc[i];
    end
    acc_shr = acc_sel >>> k;
    in_ext  = DW'(in);
    d       = in_ext - acc_shr[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        y[i]   <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        y[i]   <= '0;
      end
    end else if (take) begin
      for (int i = 0; i < NCH; i++) begin
        if (in_ch == CHW'(i)) begin
          y[i] <= d;
          if (!freeze) acc[i] <= acc[i] + AW'(y[i]);
        end
      end
    end
  end

  logic                 v1;
  logic signed [DW-1:0] d1;
  logic [CHW-1:0]       ch1;
  logic                 ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1  <= 1'b0;
      d1  <= '0;
      ch1 <= '0;
    end else begin
      v1 <= take;
      if (take) begin
        d1  <= bypass ? in_ext : d;
        ch1 <= in_ch;
      end
    end
  end

  // d1 fits in DSZ bits exactly when its top two bits agree.
  assign ovf = d1[DW-1] ^ d1[DW-2];

  // valid is a one-cycle pulse with no ready; the consumer must take every
  // pulse. out/out_ch/sat hold their last values while valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out    <= '0;
      out_ch <= '0;
      valid  <= 1'b0;
      sat    <= 1'b0;
    end else begin
      valid <= v1;
      if (v1) begin
        out    <= ovf ? {d1[DW-1], {(DSZ-1){~d1[DW-1]}}} : d1[DSZ-1:0];
        sat    <= ovf;
        out_ch <= ch1;
      end
    end
  end

endmodule

// File: tb/tb_mc_dcb.sv
// Bench for mc_dcb (NCH=3, SMAX=8 build): directed and random steps checked
// cycle by cycle against an arithmetic reference model with an expected queue.
module tb_mc_dcb;
  localparam int DSZ  = 16;
  localparam int NCH  = 3;
  localparam int SMAX = 8;
  localparam int CHW  = 2;
  localparam int AW   = DSZ + SMAX + 1;
  localparam int DW   = DSZ + 1;
  localparam int W    = 2 + CHW + DSZ;

  logic                  clk = 1'b0;
  logic                  reset;
  logic signed [DSZ-1:0] in;
  logic [CHW-1:0]        in_ch;
  logic                  ena;
  logic [3:0]            shift;
  logic                  freeze;
  logic                  bypass;
  logic                  clr;
  logic signed [DSZ-1:0] out;
  logic [CHW-1:0]        out_ch;
  logic                  valid;
  logic                  sat;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]          exp_q[$];
  longint                acc_m [NCH];
  longint                y_m   [NCH];
  logic signed [DSZ-1:0] hold_out;
  logic [CHW-1:0]        hold_ch;
  logic                  hold_sat;

  mc_dcb #(.DSZ(DSZ), .NCH(NCH), .SMAX(SMAX), .CHW(CHW)) dut (
    .clk(clk), .reset(reset), .in(in), .in_ch(in_ch), .ena(ena),
    .shift(shift), .freeze(freeze), .bypass(bypass), .clr(clr),
    .out(out), .out_ch(out_ch), .valid(valid), .sat(sat)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic longint wrap(longint x, int b);
    longint m = longint'(1) <<< b;
    longint r = x & (m - 1);
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      acc_m[i] = 0;
      y_m[i]   = 0;
    end
    hold_out = '0;
    hold_ch  = '0;
    hold_sat = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // One clock of filter behaviour; pushes what the outputs must show two edges later.
  task automatic model_cycle(longint x, int ch, int sh, bit fr, bit bp, bit cl, bit en);
    int     k;
    longint a, d, s, o;
    longint maxv, minv;
    bit     st;
    maxv = (longint'(1) <<< (DSZ - 1)) - 1;
    minv = -maxv - 1;
    k = (sh > SMAX) ? SMAX : sh;
    if (en && ch < NCH) begin
      a = cl ? 0 : acc_m[ch];
      d = wrap(x - (a >>> k), DW);
      if (!cl) begin
        if (!fr) acc_m[ch] = wrap(acc_m[ch] + y_m[ch], AW);
        y_m[ch] = d;
      end
      s  = bp ? x : d;
      st = (s > maxv) || (s < minv);
      o  = (s > maxv) ? maxv : ((s < minv) ? minv : s);
      hold_out = DSZ'(o);
      hold_ch  = CHW'(ch);
      hold_sat = st;
      exp_q.push_back({1'b1, st, CHW'(ch), DSZ'(o)});
    end else begin
      exp_q.push_back({1'b0, hold_sat, hold_ch, hold_out});
    end
    if (cl) begin
      for (int i = 0; i < NCH; i++) begin
        acc_m[i] = 0;
        y_m[i]   = 0;
      end
    end
  endtask

  // driver: apply one cycle of inputs, advance one edge, score the outputs
  task automatic step(logic signed [DSZ-1:0] x, int ch, int sh,
                      bit fr = 1'b0, bit bp = 1'b0, bit cl = 1'b0, bit en = 1'b1);
    in     = x;
    in_ch  = CHW'(ch);
    shift  = 4'(sh);
    freeze = fr;
    bypass = bp;
    clr    = cl;
    ena    = en;
    model_cycle(longint'(x), ch, sh, fr, bp, cl, en);
    @(posedge clk);
    #1;
    check("pipe", {valid, sat, out_ch, out}, exp_q.pop_front());
  endtask

  task automatic idle();
    step('0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int v3 [NCH] = '{1000, -1000, 2000};

  initial begin
    reset = 1'b0; in = '0; in_ch = '0; ena = 1'b0; shift = '0;
    freeze = 1'b0; bypass = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {valid, sat, out_ch, out}, '0);
    reset = 1'b1;
    model_reset();

    // first sample after reset, k=10 clamps to 8
    step(1000, 0, 10);
    idle();
    check("first_out", {valid, out_ch, out}, {1'b1, 2'd0, 16'd1000});

    // asynchronous reset with samples in flight
    step(1234, 0, 3);
    step(-55, 1, 3);
    ena = 1'b0;
    reset = 1'b0;
    #1;
    check("reset_async", {valid, sat, out_ch, out}, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    // DC convergence on ch1
    for (int i = 0; i < 400; i++) step(8000, 1, 4);
    idle();
    check("dc_bound", {31'd0, (out >= -1 && out <= 1)}, 32'd1);

    // round-robin interleave
    for (int r = 0; r < 100; r++) begin
      for (int c = 0; c < NCH; c++) step(DSZ'(v3[c]), c, 6);
    end
    idle();

    // saturation: converge ch0 low, then step high
    for (int i = 0; i < 400; i++) step(-32768, 0, 4);
    step(32767, 0, 4);
    idle();
    check("sat_hi", {valid, sat, out}, {1'b1, 1'b1, 16'h7fff});
    for (int i = 0; i < 20; i++) step(0, 0, 4);

    // freeze on cleared ch2
    step('0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(500, 2, 5, 1'b1);
    idle();
    check("freeze_hold", {valid, out}, {1'b1, 16'd500});

    // bypass
    for (int i = 0; i < 20; i++)
      step(DSZ'($urandom), $urandom_range(0, NCH - 1), $urandom_range(0, 15), 1'b0, 1'b1);
    step(-12345, 1, 3, 1'b0, 1'b1);
    idle();
    check("bypass_eq", {valid, out_ch, out}, {1'b1, 2'd1, 16'hcfc7});

    // clr together with a sample
    step(300, 2, 7, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    check("clr_out", {valid, out}, {1'b1, 16'd300});
    step(300, 2, 7);
    idle();
    check("clr_next", {valid, out}, {1'b1, 16'd300});

    // illegal channel is dropped
    step(777, NCH, 5);
    idle();
    check("illegal_ch", {31'd0, valid}, 32'd0);

    // shift above SMAX on ch1
    for (int i = 0; i < 40; i++) step(DSZ'($urandom_range(0, 4000)), 1, 15);

    // random mix
    for (int i = 0; i < 800; i++)
      step(DSZ'($urandom), $urandom_range(0, 3), $urandom_range(0, 15),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0));
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
